alarm_controller: RTL and testbench

ALARM_CONTROLLER -- requirements
Module: alarm_controller

---
 rtl/alarm_controller.sv | 125 ++++++++++++
 tb/tb_alarm_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm clock controller: arms on enable, rings on a rising time/alarm match,
// and supports snooze, stop and an auto-stop timeout counted in 1 Hz ticks.
module alarm_controller #(
  parameter int SNOOZE_SECS = 300,
  parameter int RING_SECS   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       snooze,
  input  logic       stop,
  input  logic [3:0] alhourMSB,
  input  logic [3:0] alhourLSB,
  input  logic [3:0] alminMSB,
  input  logic [3:0] alminLSB,
  input  logic [3:0] alsecMSB,
  input  logic [3:0] alsecLSB,
  input  logic [3:0] tmhourMSB,
  input  logic [3:0] tmhourLSB,
  input  logic [3:0] tmminMSB,
  input  logic [3:0] tmminLSB,
  input  logic [3:0] tmsecMSB,
  input  logic [3:0] tmsecLSB,
  output logic       ringing,
  output logic [1:0] state,
  output logic [8:0] remaining
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZING = 2'd3
  } state_t;

  localparam logic [8:0] RING_LD   = 9'(RING_SECS);
  localparam logic [8:0] SNOOZE_LD = 9'(SNOOZE_SECS);

  state_t     state_q, state_d;
  logic [8:0] rem_q, rem_d;
  logic       match, match_q, trigger;

  assign match = (tmhourMSB == alhourMSB) && (tmhourLSB == alhourLSB) &&
                 (tmminMSB  == alminMSB)  && (tmminLSB  == alminLSB)  &&
                 (tmsecMSB  == alsecMSB)  && (tmsecLSB  == alsecLSB);

  // Only a rising match triggers, so arming onto a held match stays quiet.
  assign trigger = match && !match_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      match_q <= match;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (!enable) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARMED;
          rem_d   = '0;
        end
        ARMED: begin
          rem_d = '0;
          if (trigger) begin
            state_d = RINGING;
            rem_d   = RING_LD;
          end
        end
        RINGING: begin
          if (stop) begin
            state_d = ARMED;
            rem_d   = '0;
          end else if (snooze) begin
            state_d = SNOOZING;
            rem_d   = SNOOZE_LD;
          end else if (tick) begin
            if (rem_q <= 9'd1) begin
              state_d = ARMED;
              rem_d   = '0;
            end else begin
              rem_d = rem_q - 9'd1;
            end
          end
        end
        SNOOZING: begin
          if (stop) begin
            state_d = ARMED;
            rem_d   = '0;
          end else if (tick) begin
            if (rem_q <= 9'd1) begin
              state_d = RINGING;
              rem_d   = RING_LD;
            end else begin
              rem_d = rem_q - 9'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    state     = state_q;
    ringing   = (state_q == RINGING);
    remaining = rem_q;
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed vector table, multi-cycle sequences,
// then randomized stimulus against a rule-based reference model.
module tb_alarm_controller;

  localparam int SN = 300;
  localparam int RG = 60;

  logic       clk = 1'b0;
  logic       reset, tick, enable, snooze, stop;
  logic [3:0] al [6];
  logic [3:0] tm [6];
  logic       ringing;
  logic [1:0] state;
  logic [8:0] remaining;

  int pass_cnt = 0;
  int total    = 0;

  // reference model
  int m_state, m_rem;
  bit m_prev;

  typedef struct {
    bit en, sn, st, tk, mt;
    int es, er, erem;
  } vec_t;

  vec_t tbl [19];

  alarm_controller #(.SNOOZE_SECS(SN), .RING_SECS(RG)) dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .snooze(snooze), .stop(stop),
    .alhourMSB(al[0]), .alhourLSB(al[1]), .alminMSB(al[2]),
    .alminLSB(al[3]), .alsecMSB(al[4]), .alsecLSB(al[5]),
    .tmhourMSB(tm[0]), .tmhourLSB(tm[1]), .tmminMSB(tm[2]),
    .tmminLSB(tm[3]), .tmsecMSB(tm[4]), .tmsecLSB(tm[5]),
    .ringing(ringing), .state(state), .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic chk_out(input string name, input int es, input int er, input int erem);
    chk({name, ".state"}, int'(state), es);
    chk({name, ".ringing"}, int'(ringing), er);
    chk({name, ".remaining"}, int'(remaining), erem);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_match(input bit m);
    for (int unsigned i = 0; i < 6; i++) tm[i] = al[i];
    if (!m) begin
      tm[4] = 4'd5;
      tm[5] = 4'd9;
      tm[3] = 4'd9;
      tm[2] = 4'd2;
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  // Spec rules with priority enable > stop > snooze > expiry > trigger.
  task automatic model_step();
    bit match, trig;
    match = 1'b1;
    for (int unsigned i = 0; i < 6; i++) if (tm[i] != al[i]) match = 1'b0;
    if (reset) begin
      m_state = 0; m_rem = 0; m_prev = 1'b0;
      return;
    end
    trig   = match && !m_prev;
    m_prev = match;
    if (!enable) begin
      m_state = 0; m_rem = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (trig) begin m_state = 2; m_rem = RG; end
    end else if (stop) begin
      m_state = 1; m_rem = 0;
    end else if (snooze && m_state == 2) begin
      m_state = 3; m_rem = SN;
    end else if (tick) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        if (m_state == 2) m_state = 1;
        else begin m_state = 2; m_rem = RG; end
      end
    end
  endtask

  initial begin
    reset = 1'b1; tick = 0; enable = 0; snooze = 0; stop = 0;
    al[0] = 4'd0; al[1] = 4'd7; al[2] = 4'd3; al[3] = 4'd0; al[4] = 4'd0; al[5] = 4'd0;
    set_match(1'b0);
    #2;
    chk_out("reset_async", 0, 0, 0);
    cyc(); cyc();
    chk_out("reset_held", 0, 0, 0);
    reset = 1'b0;

    //           en sn st tk mt  st r  rem
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 1, 2, 1, 60};
    tbl[4]  = '{1, 0, 0, 1, 1, 2, 1, 59};
    tbl[5]  = '{1, 0, 0, 1, 1, 2, 1, 58};
    tbl[6]  = '{1, 1, 0, 0, 1, 3, 0, 300};
    tbl[7]  = '{1, 1, 0, 1, 1, 3, 0, 299};
    tbl[8]  = '{1, 0, 1, 0, 1, 1, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 1, 1, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 1, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 1, 2, 1, 60};
    tbl[12] = '{0, 0, 0, 0, 1, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 1, 1, 0, 0};
    tbl[14] = '{1, 0, 0, 0, 1, 1, 0, 0};
    tbl[15] = '{1, 0, 0, 0, 0, 1, 0, 0};
    tbl[16] = '{1, 0, 0, 0, 1, 2, 1, 60};
    tbl[17] = '{1, 1, 1, 1, 1, 1, 0, 0};
    tbl[18] = '{0, 0, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 19; i++) begin
      enable = tbl[i].en; snooze = tbl[i].sn; stop = tbl[i].st; tick = tbl[i].tk;
      set_match(tbl[i].mt);
      cyc();
      chk_out($sformatf("vec%0d", i), tbl[i].es, tbl[i].er, tbl[i].erem);
    end
    snooze = 0; stop = 0; tick = 0;

    // 07:29:59 -> 07:30:00, then full auto-stop timeout
    enable = 1'b1; set_match(1'b0); cyc();
    chk("arm.state", int'(state), 1);
    set_match(1'b1); cyc();
    chk_out("trigger", 2, 1, 60);
    for (int i = 1; i <= RG; i++) begin
      do_tick();
      if (i < RG) chk_out($sformatf("ring_tick%0d", i), 2, 1, RG - i);
      cyc();
    end
    chk_out("ring_expired", 1, 0, 0);
    for (int i = 0; i < 5; i++) do_tick();
    chk_out("no_retrigger", 1, 0, 0);

    // snooze then full snooze period back to ringing
    set_match(1'b0); cyc(); set_match(1'b1); cyc();
    chk_out("retrigger", 2, 1, 60);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk_out("snooze_load", 3, 0, 300);
    for (int i = 1; i <= SN; i++) begin
      do_tick();
      if (i == SN - 1) chk_out("snooze_last", 3, 0, 1);
    end
    chk_out("snooze_expire", 2, 1, 60);

    // snooze on the expiring ring tick wins; stop on the expiring snooze tick wins
    for (int i = 1; i < RG; i++) do_tick();
    chk_out("ring_at_one", 2, 1, 1);
    tick = 1'b1; snooze = 1'b1; cyc(); tick = 1'b0; snooze = 1'b0;
    chk_out("snooze_beats_expiry", 3, 0, 300);
    for (int i = 1; i < SN; i++) do_tick();
    chk_out("snooze_at_one", 3, 0, 1);
    tick = 1'b1; stop = 1'b1; cyc(); tick = 1'b0; stop = 1'b0;
    chk_out("stop_beats_expiry", 1, 0, 0);

    // asynchronous reset mid-snooze
    set_match(1'b0); cyc(); set_match(1'b1); cyc();
    snooze = 1'b1; cyc(); snooze = 1'b0;
    do_tick(); do_tick();
    chk_out("pre_reset", 3, 0, 298);
    #3 reset = 1'b1;
    #1 chk_out("async_reset", 0, 0, 0);
    cyc();
    reset = 1'b0;
    cyc();
    chk_out("post_reset_arm", 1, 0, 0);
    cyc();
    chk_out("post_reset_hold", 1, 0, 0);

    // randomized phase against the reference model
    reset = 1'b1; model_step(); cyc(); reset = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      enable = ($urandom_range(99) < 97);
      snooze = ($urandom_range(99) < 4);
      stop   = ($urandom_range(99) < 2);
      tick   = ($urandom_range(99) < 40);
      if ($urandom_range(99) < 15) set_match(1'b1);
      else begin
        for (int unsigned i = 0; i < 6; i++) tm[i] = 4'($urandom_range(15));
        tm[5] = al[5] ^ 4'($urandom_range(15, 1));
      end
      reset = ($urandom_range(999) < 2);
      model_step();
      cyc();
      chk_out($sformatf("rand%0d", n), m_state, (m_state == 2) ? 1 : 0, m_rem);
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
